// File: rtl/hanoi_pkg.sv
// Shared types and helpers for the parametrised Tower-of-Hanoi peg engine.
package hanoi_pkg;

  typedef enum logic [1:0] {MV_NONE, MV_OK, MV_ERR} mv_status_t;

  // Width needed to hold a disk number 1..s or a height 0..s.
  function automatic int disk_w(input int s);
    return $clog2(s + 1);
  endfunction

  // Reset image of peg 0: slot k (0 = bottom) holds disk s-k, unused slots 0.
  function automatic int reset_slot(input int s, input int k);
    return (k < s) ? (s - k) : 0;
  endfunction

endpackage

// File: rtl/hanoi_peg_engine_if.sv
// Move request/response bundle of hanoi_peg_engine; the undo input exists only with HANOI_UNDO_EN.
interface hanoi_peg_engine_if #(parameter int P = 3);
  localparam int PW = $clog2(P);

  // Handshake: mv_valid qualifies fr/to for exactly one cycle and there is no
  // ready; every request is consumed at the edge it is sampled on and answered
  // by a one-cycle mv_ok_o or mv_err_o pulse visible after that edge.
  logic          mv_valid;
  logic [PW-1:0] fr;
  logic [PW-1:0] to;
  logic          mv_ok_o;
  logic          mv_err_o;
`ifdef HANOI_UNDO_EN
  logic          undo;

  modport master (output mv_valid, fr, to, undo, input mv_ok_o, mv_err_o);
  modport slave  (input mv_valid, fr, to, undo, output mv_ok_o, mv_err_o);
`else
  modport master (output mv_valid, fr, to, input mv_ok_o, mv_err_o);
  modport slave  (input mv_valid, fr, to, output mv_ok_o, mv_err_o);
`endif
endinterface

// File: rtl/hanoi_peg_stack.sv
// One peg: LIFO of depth S with registered slots, height and combinational top disk.
module hanoi_peg_stack
  import hanoi_pkg::*;
#(
  parameter int S         = 3,
  parameter int DW        = 2,
  parameter bit INIT_FULL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [DW-1:0]   push_disk,
  output logic [S*DW-1:0] slots_o,
  output logic [DW-1:0]   top_o,
  output logic [DW-1:0]   height_o
);

  logic [DW-1:0] slot_q [S];
  logic [DW-1:0] height_q;

  // The engine never pops and pushes the same peg in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < S; k++) slot_q[k] <= INIT_FULL ? DW'(reset_slot(S, k)) : '0;
      height_q <= INIT_FULL ? DW'(S) : '0;
    end else if (pop) begin
      for (int k = 0; k < S; k++) if (32'(height_q) == k + 1) slot_q[k] <= '0;
      height_q <= height_q - DW'(1);
    end else if (push) begin
      for (int k = 0; k < S; k++) if (32'(height_q) == k) slot_q[k] <= push_disk;
      height_q <= height_q + DW'(1);
    end
  end

  always_comb begin
    slots_o = '0;
    top_o   = '0;
    for (int k = 0; k < S; k++) begin
      slots_o[k*DW +: DW] = slot_q[k];
      if (32'(height_q) == k + 1) top_o = slot_q[k];
    end
  end

  assign height_o = height_q;

endmodule

// File: rtl/hanoi_peg_engine.sv
// Tower-of-Hanoi engine: S disks on P pegs, one checked move per cycle.
// Optional one-step undo is compiled in with HANOI_UNDO_EN.
module hanoi_peg_engine
  import hanoi_pkg::*;
#(
  parameter int S   = 3,
  parameter int P   = 3,
  parameter int TGT = P - 1,
  parameter int CW  = 16,
  localparam int DW = disk_w(S),
  localparam int PW = $clog2(P)
) (
  input  logic               clk,
  input  logic               rst,
  hanoi_peg_engine_if.slave  mv,
  output logic [P*S*DW-1:0]  peg_o,
  output logic [P*DW-1:0]    height_o,
  output logic [CW-1:0]      move_cnt_o,
  output logic [CW-1:0]      err_cnt_o,
  output logic               solved_o
);

  // Index space padded to 2**PW so any fr/to value reads a defined (empty) peg.
  localparam int NP = 1 << PW;

  logic [NP-1:0][DW-1:0] h_a;
  logic [NP-1:0][DW-1:0] t_a;
  logic [P-1:0]          push, pop;
  logic [DW-1:0]         mv_disk;
  logic [PW-1:0]         src, dst;
  logic                  legal, do_mv, cnt_dec;
  logic [DW-1:0]         h_tgt_n;
  mv_status_t            st;
  logic                  ok_q, err_q, solved_q;
  logic [CW-1:0]         mcnt_q, ecnt_q;
`ifdef HANOI_UNDO_EN
  logic                  hist_v_q;
  logic [PW-1:0]         hist_fr_q, hist_to_q;
`endif

  for (genvar p = 0; p < NP; p++) begin : g_peg
    if (p < P) begin : g_real
      hanoi_peg_stack #(.S(S), .DW(DW), .INIT_FULL(p == 0)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push[p]),
        .pop       (pop[p]),
        .push_disk (mv_disk),
        .slots_o   (peg_o[p*S*DW +: S*DW]),
        .top_o     (t_a[p]),
        .height_o  (h_a[p])
      );
      assign height_o[p*DW +: DW] = h_a[p];
    end else begin : g_pad
      assign h_a[p] = '0;
      assign t_a[p] = '0;
    end
  end

  assign legal = (32'(mv.fr) < P) && (32'(mv.to) < P) && (mv.fr != mv.to) &&
                 (h_a[mv.fr] != '0) &&
                 !((h_a[mv.to] != '0) && (t_a[mv.fr] > t_a[mv.to]));

  // Undo replays the remembered move backwards; a concurrent request is dropped.
  always_comb begin
    src     = mv.fr;
    dst     = mv.to;
    do_mv   = 1'b0;
    cnt_dec = 1'b0;
    st      = MV_NONE;
`ifdef HANOI_UNDO_EN
    if (mv.undo) begin
      src = hist_to_q;
      dst = hist_fr_q;
      if (hist_v_q) begin
        do_mv   = 1'b1;
        cnt_dec = 1'b1;
        st      = MV_OK;
      end else begin
        st = MV_ERR;
      end
    end else
`endif
    if (mv.mv_valid) begin
      if (legal) begin
        do_mv = 1'b1;
        st    = MV_OK;
      end else begin
        st = MV_ERR;
      end
    end
  end

  always_comb begin
    mv_disk = t_a[src];
    push    = '0;
    pop     = '0;
    for (int p = 0; p < P; p++) begin
      pop[p]  = do_mv && (32'(src) == p);
      push[p] = do_mv && (32'(dst) == p);
    end
    h_tgt_n = h_a[TGT] + DW'(push[TGT]) - DW'(pop[TGT]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      mcnt_q   <= '0;
      ecnt_q   <= '0;
      solved_q <= 1'b0;
    end else begin
      ok_q     <= (st == MV_OK);
      err_q    <= (st == MV_ERR);
      solved_q <= (h_tgt_n == DW'(S));
      if (st == MV_ERR && ecnt_q != '1) ecnt_q <= ecnt_q + CW'(1);
      if (st == MV_OK) begin
        // A saturated count no longer reflects the true total, so undo leaves it.
        if (cnt_dec) begin
          if (mcnt_q != '0 && mcnt_q != '1) mcnt_q <= mcnt_q - CW'(1);
        end else if (mcnt_q != '1) begin
          mcnt_q <= mcnt_q + CW'(1);
        end
      end
    end
  end

`ifdef HANOI_UNDO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_v_q  <= 1'b0;
      hist_fr_q <= '0;
      hist_to_q <= '0;
    end else if (mv.undo) begin
      hist_v_q <= 1'b0;
    end else if (do_mv) begin
      hist_v_q  <= 1'b1;
      hist_fr_q <= mv.fr;
      hist_to_q <= mv.to;
    end
  end
`endif

  assign mv.mv_ok_o  = ok_q;
  assign mv.mv_err_o = err_q;
  assign move_cnt_o  = mcnt_q;
  assign err_cnt_o   = ecnt_q;
  assign solved_o    = solved_q;

endmodule

// File: tb/tb_hanoi_peg_engine.sv
// Bench for hanoi_peg_engine: directed and random moves against a peg/disk model;
// a second instance with CW=3 shares the stimulus to exercise counter saturation.
module tb_hanoi_peg_engine;
  import hanoi_pkg::*;

  localparam int S   = 3;
  localparam int P   = 3;
  localparam int TGT = 2;
  localparam int DW  = disk_w(S);
  localparam int PW  = $clog2(P);

  typedef struct packed {
    logic              ok;
    logic              err;
    logic [P*S*DW-1:0] peg;
    logic [P*DW-1:0]   hgt;
    logic [15:0]       mc;
    logic [15:0]       ec;
    logic [2:0]        mc2;
    logic [2:0]        ec2;
    logic              solved;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hanoi_peg_engine_if #(.P(P)) mv ();
  hanoi_peg_engine_if #(.P(P)) mv2 ();
  assign mv2.mv_valid = mv.mv_valid;
  assign mv2.fr       = mv.fr;
  assign mv2.to       = mv.to;
`ifdef HANOI_UNDO_EN
  assign mv2.undo     = mv.undo;
`endif

  logic [P*S*DW-1:0] peg, peg2;
  logic [P*DW-1:0]   height, height2;
  logic [15:0]       mcnt, ecnt;
  logic [2:0]        mcnt2, ecnt2;
  logic              solved, solved2;

  hanoi_peg_engine #(.S(S), .P(P), .TGT(TGT), .CW(16)) dut (
    .clk(clk), .rst(rst), .mv(mv), .peg_o(peg), .height_o(height),
    .move_cnt_o(mcnt), .err_cnt_o(ecnt), .solved_o(solved)
  );

  hanoi_peg_engine #(.S(S), .P(P), .TGT(TGT), .CW(3)) dut_sat (
    .clk(clk), .rst(rst), .mv(mv2), .peg_o(peg2), .height_o(height2),
    .move_cnt_o(mcnt2), .err_cnt_o(ecnt2), .solved_o(solved2)
  );

  // ---------------- reference model ----------------
  int stk [P][S];
  int n   [P];
  int mc  [2];
  int ec  [2];
  int cmax[2] = '{65535, 7};
  int hv, hfr, hto;

  task automatic model_reset();
    for (int p = 0; p < P; p++) begin
      n[p] = 0;
      for (int k = 0; k < S; k++) stk[p][k] = 0;
    end
    for (int k = 0; k < S; k++) stk[0][k] = S - k;
    n[0] = S;
    mc = '{0, 0};
    ec = '{0, 0};
    hv = 0;
  endtask

  task automatic move_disk(input int f, input int t);
    int d;
    d = stk[f][n[f]-1];
    stk[f][n[f]-1] = 0;
    n[f]--;
    stk[t][n[t]] = d;
    n[t]++;
  endtask

  task automatic model_step(input logic r, input logic v, input int f, input int t,
                            input logic u, output logic ok, output logic err);
    bit legal;
    ok = 1'b0;
    err = 1'b0;
    if (r) begin
      model_reset();
    end else if (u) begin
      if (hv != 0) begin
        move_disk(hto, hfr);
        for (int i = 0; i < 2; i++) if (mc[i] > 0 && mc[i] < cmax[i]) mc[i]--;
        hv = 0;
        ok = 1'b1;
      end else begin
        err = 1'b1;
        for (int i = 0; i < 2; i++) if (ec[i] < cmax[i]) ec[i]++;
      end
    end else if (v) begin
      legal = (f < P) && (t < P) && (f != t);
      if (legal) legal = (n[f] > 0);
      if (legal && n[t] > 0) legal = (stk[f][n[f]-1] < stk[t][n[t]-1]);
      if (legal) begin
        move_disk(f, t);
        for (int i = 0; i < 2; i++) if (mc[i] < cmax[i]) mc[i]++;
        hv = 1; hfr = f; hto = t;
        ok = 1'b1;
      end else begin
        err = 1'b1;
        for (int i = 0; i < 2; i++) if (ec[i] < cmax[i]) ec[i]++;
      end
    end
  endtask

  function automatic exp_t build(input logic ok, input logic err);
    exp_t e;
    e = '0;
    e.ok  = ok;
    e.err = err;
    for (int p = 0; p < P; p++) begin
      e.hgt[p*DW +: DW] = DW'(n[p]);
      for (int k = 0; k < S; k++) e.peg[(p*S+k)*DW +: DW] = DW'(stk[p][k]);
    end
    e.mc     = 16'(mc[0]);
    e.ec     = 16'(ec[0]);
    e.mc2    = 3'(mc[1]);
    e.ec2    = 3'(ec[1]);
    e.solved = (n[TGT] == S);
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mv_ok",    64'(mv.mv_ok_o),  64'(e.ok));
        chk("mv_err",   64'(mv.mv_err_o), 64'(e.err));
        chk("peg",      64'(peg),         64'(e.peg));
        chk("height",   64'(height),      64'(e.hgt));
        chk("move_cnt", 64'(mcnt),        64'(e.mc));
        chk("err_cnt",  64'(ecnt),        64'(e.ec));
        chk("solved",   64'(solved),      64'(e.solved));
        chk("sat_move_cnt", 64'(mcnt2),   64'(e.mc2));
        chk("sat_err_cnt",  64'(ecnt2),   64'(e.ec2));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic v, input int f, input int t,
                       input logic u = 1'b0);
    logic ok, err;
    @(negedge clk);
    rst         = r;
    mv.mv_valid = v;
    mv.fr       = PW'(f);
    mv.to       = PW'(t);
`ifdef HANOI_UNDO_EN
    mv.undo     = u;
`endif
    model_step(r, v, f, t, u, ok, err);
    exp_q.push_back(build(ok, err));
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'b0, 0, 0);
  endtask

  int opt_fr[7] = '{0, 0, 2, 0, 1, 1, 0};
  int opt_to[7] = '{2, 1, 1, 2, 0, 2, 2};

  initial begin : stimulus
    logic r, v, u;
    int f, t;
    mv.mv_valid = 1'b0;
    mv.fr = '0;
    mv.to = '0;
`ifdef HANOI_UNDO_EN
    mv.undo = 1'b0;
`endif
    model_reset();

    // reset, then optimal solution with an idle cycle after
    do_reset(2);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, opt_fr[i], opt_to[i]);
    drive(1'b0, 1'b0, 0, 0);
    // moves remain accepted after solved; moving off TGT clears solved
    drive(1'b0, 1'b1, 2, 0);

    // illegal moves: larger onto smaller, same peg, out-of-range peg
    do_reset(1);
    drive(1'b0, 1'b1, 0, 1);
    drive(1'b0, 1'b1, 0, 1);
    drive(1'b0, 1'b1, 1, 1);
    drive(1'b0, 1'b1, 0, 3);

    // reset overrides a concurrent request mid-sequence
    do_reset(1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, opt_fr[i], opt_to[i]);
    drive(1'b1, 1'b1, 0, 2);
    drive(1'b0, 1'b0, 0, 0);

    // 9 alternating legal moves saturate the CW=3 counter; then empty source
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, (i % 2 == 0) ? 0 : 1, (i % 2 == 0) ? 1 : 0);
    drive(1'b0, 1'b1, 2, 0);

`ifdef HANOI_UNDO_EN
    do_reset(1);
    drive(1'b0, 1'b1, 0, 2);
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    drive(1'b0, 1'b0, 0, 0, 1'b1);
    drive(1'b0, 1'b1, 0, 2);
    drive(1'b0, 1'b1, 0, 1, 1'b1);
    drive(1'b0, 1'b1, 0, 1, 1'b1);
`endif

    // random play with occasional resets
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 79) == 0);
      v = ($urandom_range(0, 9) != 0);
      f = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
      t = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
`ifdef HANOI_UNDO_EN
      u = ($urandom_range(0, 7) == 0);
`else
      u = 1'b0;
`endif
      drive(r, v, f, t, u);
    end
    drive(1'b0, 1'b0, 0, 0);

    // let the monitor drain, bounded
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
